// File: rtl/vram_pkg.sv
// Shared definitions for the text VRAM arbiter.
// Holds the VRAM geometry and the tag type used to track which requester
// owns the BRAM read that is currently in flight.
package vram_pkg;

  localparam int ADDR_W     = 12;   // word address width, matches colour mapper word_addr
  localparam int DATA_W     = 32;   // VRAM word, 4 glyph bytes
  localparam int VRAM_DEPTH = 600;  // 80x30 characters / 4 per word

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_DISP,
    TAG_CPU_RD,
    TAG_CPU_WR
  } tag_t;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port text VRAM arbiter.
// Shares one BRAM port between the display fetch path (priority) and the
// CPU/AXI access path (forced through after MAX_WAIT consecutive losses).
// Every request sees a fixed two-cycle latency and one op may issue per cycle.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   disp_req/disp_addr         display read request pulse and word address
//   disp_valid/disp_rdata      display read response (one-cycle pulse)
//   cpu_req/cpu_we/cpu_be      CPU level request, write flag, byte enables
//   cpu_addr/cpu_wdata         CPU word address and write data
//   cpu_ack/cpu_rdata          CPU completion pulse and read data
//   disp_overrun               sticky flag: a display request was dropped
//   bram_en/we/addr/wdata      BRAM port, driven combinationally for the grant
//   bram_rdata                 BRAM read data, one cycle after an enabled read
//
// Response tag pipeline
//   tag        | meaning
//   TAG_NONE   | nothing issued last cycle
//   TAG_DISP   | display read issued last cycle
//   TAG_CPU_RD | CPU read issued last cycle
//   TAG_CPU_WR | CPU write issued last cycle
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int MAX_WAIT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              disp_overrun,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(VRAM_DEPTH);

  logic              hold_full;
  logic [ADDR_W-1:0] hold_addr;
  logic              cpu_busy;
  logic [WAIT_W-1:0] wait_cnt;
  tag_t              tag_q;
  logic              tag_ok_q;

  logic              disp_cand;
  logic              cpu_cand;
  logic              grant_cpu;
  logic              grant_disp;
  logic [ADDR_W-1:0] issue_addr;
  logic              addr_ok;
  tag_t              issue_tag;

  always_comb begin
    disp_cand  = hold_full | disp_req;
    cpu_cand   = cpu_req & ~cpu_busy;
    grant_cpu  = 1'b0;
    grant_disp = 1'b0;
    // Nothing issues while reset is held so the BRAM port reads all zero.
    if (!reset) begin
      grant_cpu  = cpu_cand & (~disp_cand | (wait_cnt == WAIT_MAX));
      grant_disp = disp_cand & ~grant_cpu;
    end

    // The hold entry is older than a same-cycle disp_req, so it goes first.
    issue_addr = grant_cpu ? cpu_addr : (hold_full ? hold_addr : disp_addr);
    addr_ok    = issue_addr < DEPTH_LIM;

    bram_en    = (grant_cpu | grant_disp) & addr_ok;
    bram_we    = (grant_cpu & cpu_we & addr_ok) ? cpu_be : 4'b0000;
    bram_addr  = bram_en ? issue_addr : '0;
    bram_wdata = (grant_cpu & cpu_we & addr_ok) ? cpu_wdata : '0;

    issue_tag = TAG_NONE;
    if (grant_disp)     issue_tag = TAG_DISP;
    else if (grant_cpu) issue_tag = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full    <= 1'b0;
      hold_addr    <= '0;
      cpu_busy     <= 1'b0;
      wait_cnt     <= '0;
      tag_q        <= TAG_NONE;
      tag_ok_q     <= 1'b0;
      disp_valid   <= 1'b0;
      disp_rdata   <= '0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
      disp_overrun <= 1'b0;
    end else begin
      tag_q    <= issue_tag;
      tag_ok_q <= addr_ok;

      // Out-of-range ops never enabled the BRAM, so they return zero.
      disp_valid <= (tag_q == TAG_DISP);
      cpu_ack    <= (tag_q == TAG_CPU_RD) || (tag_q == TAG_CPU_WR);
      if (tag_q == TAG_DISP)   disp_rdata <= tag_ok_q ? bram_rdata : '0;
      if (tag_q == TAG_CPU_RD) cpu_rdata  <= tag_ok_q ? bram_rdata : '0;

      if (grant_cpu)    cpu_busy <= 1'b1;
      else if (cpu_ack) cpu_busy <= 1'b0;

      if (grant_cpu || !cpu_req)
        wait_cnt <= '0;
      else if (cpu_cand && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 1'b1;

      if (hold_full && grant_disp) begin
        // Hold entry leaves; a same-cycle request refills it.
        hold_full <= disp_req;
        if (disp_req) hold_addr <= disp_addr;
      end else if (disp_req && !grant_disp) begin
        if (hold_full) begin
          disp_overrun <= 1'b1;
        end else begin
          hold_full <= 1'b1;
          hold_addr <= disp_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int MAX_WAIT = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_rdata;
  logic              cpu_req;
  logic              cpu_we;
  logic [3:0]        cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              disp_overrun;
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_rdata(disp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .disp_overrun(disp_overrun),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  // BRAM environment: one-cycle read latency, byte-masked writes
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    logic [31:0] w;
    if (bram_en) begin
      bram_rdata <= mem[bram_addr];
      w = mem[bram_addr];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) w[8*b +: 8] = bram_wdata[8*b +: 8];
      mem[bram_addr] <= w;
    end
  end

  // Reference model state (transaction level)
  typedef struct {
    int          due;
    bit          is_disp;
    bit          is_rd;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic [31:0] ref_mem [0:4095];
  resp_t       rq[$];
  logic [11:0] dq[$];
  cmd_t        cq[$];
  cmd_t        cur;
  bit          cpu_active;
  int          losses;
  int          cpu_until;
  int          cyc;
  bit          m_overrun;
  logic [31:0] m_disp_rdata;
  logic [31:0] m_cpu_rdata;
  bit          cmp_en;
  int          errors;
  int          checks;

  logic        s_dv, s_ack, s_ovr, s_en;
  logic [31:0] s_drd, s_crd, s_wdata;
  logic [3:0]  s_we;
  logic [11:0] s_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit rst, input bit dreq, input logic [11:0] daddr);
    bit          e_dv, e_ack, e_en, e_ovr, cw, dw, gc, gd, ok;
    logic [3:0]  e_we;
    logic [11:0] e_addr, a;
    logic [31:0] e_wdata, w;
    logic [11:0] tmp[$];
    resp_t       r;

    @(negedge clk);
    if (!cpu_active && cq.size() > 0) begin
      cur = cq.pop_front();
      cpu_active = 1'b1;
    end
    reset     = rst;
    disp_req  = dreq;
    disp_addr = daddr;
    cpu_req   = cpu_active;
    cpu_we    = cur.we;
    cpu_be    = cur.be;
    cpu_addr  = cur.addr;
    cpu_wdata = cur.wdata;
    #1;
    s_dv = disp_valid; s_drd = disp_rdata; s_ack = cpu_ack; s_crd = cpu_rdata;
    s_ovr = disp_overrun; s_en = bram_en; s_we = bram_we; s_addr = bram_addr;
    s_wdata = bram_wdata;

    // Responses due this cycle
    e_dv = 1'b0; e_ack = 1'b0; e_ovr = m_overrun;
    while (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.is_disp) begin
        e_dv = 1'b1;
        m_disp_rdata = r.data;
      end else begin
        e_ack = 1'b1;
        if (r.is_rd) m_cpu_rdata = r.data;
      end
    end

    // Issue decision for this cycle
    e_en = 1'b0; e_we = 4'b0; e_addr = '0; e_wdata = '0;
    if (!rst) begin
      tmp = dq;
      if (dreq) tmp.push_back(daddr);
      dw = tmp.size() > 0;
      cw = cpu_active && (cyc > cpu_until);
      gc = cw && (!dw || losses == MAX_WAIT);
      gd = dw && !gc;
      if (gd) begin
        a = tmp.pop_front();
        ok = a < VRAM_DEPTH;
        e_en = ok; e_addr = a;
        r.due = cyc + 2; r.is_disp = 1'b1; r.is_rd = 1'b1;
        r.data = ok ? ref_mem[a] : 32'h0;
        rq.push_back(r);
      end
      if (gc) begin
        a = cur.addr;
        ok = a < VRAM_DEPTH;
        e_en = ok; e_addr = a;
        r.due = cyc + 2; r.is_disp = 1'b0; r.is_rd = !cur.we; r.data = 32'h0;
        if (cur.we) begin
          if (ok) begin
            e_we = cur.be; e_wdata = cur.wdata;
            w = ref_mem[a];
            for (int b = 0; b < 4; b++)
              if (cur.be[b]) w[8*b +: 8] = cur.wdata[8*b +: 8];
            ref_mem[a] = w;
          end
        end else if (ok) begin
          r.data = ref_mem[a];
        end
        rq.push_back(r);
        cpu_until = cyc + 2;
      end
      if (tmp.size() > 1) begin
        void'(tmp.pop_back());
        m_overrun = 1'b1;
      end
      if (gc || !cpu_active) losses = 0;
      else if (cw && losses < MAX_WAIT) losses++;
      dq = tmp;
    end

    if (cmp_en) begin
      chk("disp_valid", 32'(s_dv), 32'(e_dv));
      chk("disp_rdata", s_drd, m_disp_rdata);
      chk("cpu_ack", 32'(s_ack), 32'(e_ack));
      chk("cpu_rdata", s_crd, m_cpu_rdata);
      chk("disp_overrun", 32'(s_ovr), 32'(e_ovr));
      chk("bram_en", 32'(s_en), 32'(e_en));
      chk("bram_we", 32'(s_we), 32'(e_we));
      if (e_en) chk("bram_addr", 32'(s_addr), 32'(e_addr));
      if (e_we != 4'b0) chk("bram_wdata", s_wdata, e_wdata);
    end

    if (rst) begin
      rq.delete(); dq.delete();
      losses = 0; cpu_until = -1; m_overrun = 1'b0;
      m_disp_rdata = '0; m_cpu_rdata = '0;
      cpu_active = 1'b0;
      cmp_en = 1'b1;
    end
    if (e_ack) cpu_active = 1'b0;
    cyc++;
  endtask

  initial begin
    int first, second, grant, nvalid, k, en_seen;
    logic [31:0] rd;

    errors = 0; checks = 0; cyc = 0; cmp_en = 1'b0;
    cpu_active = 1'b0; cur = '{default: 0}; cpu_until = -1; losses = 0;
    m_overrun = 1'b0; m_disp_rdata = '0; m_cpu_rdata = '0;
    reset = 1'b1; disp_req = 1'b0; disp_addr = '0; cpu_req = 1'b0;
    cpu_we = 1'b0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 4096; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[5] = 32'h41424344; ref_mem[5] = 32'h41424344;
    for (int i = 0; i < 20; i++) begin
      mem[100+i] = 32'hA000_0000 + i; ref_mem[100+i] = 32'hA000_0000 + i;
    end
    mem[20] = 32'h12345678; ref_mem[20] = 32'h12345678;
    mem[21] = 32'hCAFE0021; ref_mem[21] = 32'hCAFE0021;
    mem[22] = 32'hCAFE0022; ref_mem[22] = 32'hCAFE0022;

    // Reset state
    step(1'b1, 1'b0, 12'd0);
    step(1'b1, 1'b0, 12'd0);
    step(1'b0, 1'b0, 12'd0);
    chk("rst_disp_valid", 32'(s_dv), 32'd0);
    chk("rst_cpu_ack", 32'(s_ack), 32'd0);
    chk("rst_overrun", 32'(s_ovr), 32'd0);
    chk("rst_bram_en", 32'(s_en), 32'd0);
    chk("rst_disp_rdata", s_drd, 32'd0);

    // Single display read of addr 5
    step(1'b0, 1'b1, 12'd5);
    chk("d5_bram_en", 32'(s_en), 32'd1);
    chk("d5_bram_addr", 32'(s_addr), 32'd5);
    step(1'b0, 1'b0, 12'd0);
    chk("d5_valid_t1", 32'(s_dv), 32'd0);
    step(1'b0, 1'b0, 12'd0);
    chk("d5_valid_t2", 32'(s_dv), 32'd1);
    chk("d5_rdata_t2", s_drd, 32'h41424344);
    chk("d5_no_ack", 32'(s_ack), 32'd0);

    // CPU byte-masked write then read back
    cq.push_back('{we: 1'b1, be: 4'b0011, addr: 12'd10, wdata: 32'hDEADBEEF});
    cq.push_back('{we: 1'b0, be: 4'b0000, addr: 12'd10, wdata: 32'h0});
    first = -1; second = -1; rd = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 12'd0);
      if (i == 0) chk("wr_bram_we", 32'(s_we), 32'h3);
      if (s_ack) begin
        if (first < 0) first = i; else second = i;
        rd = s_crd;
      end
    end
    chk("wr_ack_cycle", 32'(first), 32'd2);
    chk("rd_ack_cycle", 32'(second), 32'd5);
    chk("rd_data", rd, 32'h0000BEEF);

    // Display every cycle for 20 cycles against a pending CPU read
    cq.push_back('{we: 1'b0, be: 4'b0000, addr: 12'd20, wdata: 32'h0});
    grant = -1; first = -1; nvalid = 0;
    for (int i = 0; i < 26; i++) begin
      step(1'b0, i < 20, 12'(100 + i));
      if (s_en && s_addr == 12'd20 && grant < 0) grant = i;
      if (s_ack) first = i;
      if (s_dv) begin
        chk("cont_order", s_drd, 32'hA000_0000 + 32'(nvalid));
        nvalid++;
      end
    end
    chk("cont_cpu_grant", 32'(grant), 32'd7);
    chk("cont_cpu_ack", 32'(first), 32'd9);
    chk("cont_disp_count", 32'(nvalid), 32'd20);
    chk("cont_overrun", 32'(s_ovr), 32'd0);
    chk("cont_cpu_rdata", s_crd, 32'h12345678);

    // Second forced grant lands while the hold entry is full: one drop
    cq.push_back('{we: 1'b0, be: 4'b0000, addr: 12'd21, wdata: 32'h0});
    cq.push_back('{we: 1'b0, be: 4'b0000, addr: 12'd22, wdata: 32'h0});
    nvalid = 0;
    for (int i = 0; i < 26; i++) begin
      step(1'b0, i < 20, 12'(100 + i));
      if (i == 17) chk("ovr_before", 32'(s_ovr), 32'd0);
      if (i == 18) chk("ovr_after", 32'(s_ovr), 32'd1);
      if (s_dv) begin
        k = (nvalid < 17) ? nvalid : nvalid + 1;
        chk("ovr_order", s_drd, 32'hA000_0000 + 32'(k));
        nvalid++;
      end
    end
    chk("ovr_disp_count", 32'(nvalid), 32'd19);
    chk("ovr_cpu_rdata", s_crd, 32'hCAFE0022);

    // Out-of-range CPU read and write
    cq.push_back('{we: 1'b0, be: 4'b0000, addr: 12'd600, wdata: 32'h0});
    cq.push_back('{we: 1'b1, be: 4'b1111, addr: 12'd4095, wdata: 32'h55AA55AA});
    first = -1; second = -1; rd = 32'hFFFF_FFFF; en_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 12'd0);
      if (s_en) en_seen = 1;
      if (s_ack) begin
        if (first < 0) begin first = i; rd = s_crd; end
        else second = i;
      end
    end
    chk("oor_bram_en", 32'(en_seen), 32'd0);
    chk("oor_rd_ack", 32'(first), 32'd2);
    chk("oor_wr_ack", 32'(second), 32'd5);
    chk("oor_rdata", rd, 32'd0);
    chk("oor_overrun_sticky", 32'(s_ovr), 32'd1);

    // Reset right after a display issue cancels its response
    step(1'b0, 1'b1, 12'd5);
    step(1'b1, 1'b0, 12'd0);
    step(1'b0, 1'b0, 12'd0);
    chk("rst2_disp_valid", 32'(s_dv), 32'd0);
    chk("rst2_disp_rdata", s_drd, 32'd0);
    chk("rst2_cpu_ack", 32'(s_ack), 32'd0);
    chk("rst2_cpu_rdata", s_crd, 32'd0);
    chk("rst2_overrun", 32'(s_ovr), 32'd0);
    chk("rst2_bram_en", 32'(s_en), 32'd0);
    chk("rst2_bram_we", 32'(s_we), 32'd0);
    chk("rst2_bram_addr", 32'(s_addr), 32'd0);
    chk("rst2_bram_wdata", s_wdata, 32'd0);
    step(1'b0, 1'b0, 12'd0);
    chk("rst2_disp_valid_late", 32'(s_dv), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
